// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-SRAM responder.
//   - word / byte-enable widths
//   - response-stage field widths and total stage length
//   - dsram_resp_t: one latency-pipeline stage {valid, err, data}
//   - dsram_merge(): byte-lane write merge
package data_sram_resp_pkg;

   localparam int unsigned DSRAM_WORD_W = 32;
   localparam int unsigned DSRAM_BE_W   = 4;

   localparam int unsigned DSRAM_RESP_VALID_W = 1;
   localparam int unsigned DSRAM_RESP_ERR_W   = 1;
   localparam int unsigned DSRAM_RESP_DATA_W  = DSRAM_WORD_W;
   localparam int unsigned DSRAM_RESP_LEN     = DSRAM_RESP_VALID_W + DSRAM_RESP_ERR_W
                                                + DSRAM_RESP_DATA_W;

   typedef struct packed {
      logic                         valid;
      logic                         err;
      logic [DSRAM_RESP_DATA_W-1:0] data;
   } dsram_resp_t;

   // Replace the lanes of old_w selected by be with the matching lanes of new_w.
   function automatic logic [DSRAM_WORD_W-1:0] dsram_merge(
      input logic [DSRAM_WORD_W-1:0] old_w,
      input logic [DSRAM_WORD_W-1:0] new_w,
      input logic [DSRAM_BE_W-1:0]   be
   );
      logic [DSRAM_WORD_W-1:0] res;
      res = old_w;
      for (int k = 0; k < int'(DSRAM_BE_W); k++) begin
         if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data-SRAM bus between the EX/MEM stages (master) and the data RAM (slave).
//   en, we, addr, wdata : request, driven by the master
//   rdata, rdata_valid, addr_err : response, driven by the slave
interface data_sram_resp_if;
   import data_sram_resp_pkg::*;

   logic                    en;
   logic [DSRAM_BE_W-1:0]   we;
   logic [31:0]             addr;
   logic [DSRAM_WORD_W-1:0] wdata;
   logic [DSRAM_WORD_W-1:0] rdata;
   logic                    rdata_valid;
   logic                    addr_err;

   modport master (
      output en, we, addr, wdata,
      input  rdata, rdata_valid, addr_err
   );

   modport slave (
      input  en, we, addr, wdata,
      output rdata, rdata_valid, addr_err
   );
endinterface

// File: rtl/dsram_lat_pipe.sv
// Fixed-latency response pipeline: LAT stages of {valid, err, data}, shifting every cycle.
//   clk, resetn : clock, async active-low reset (clears valid/err only)
//   resp_i      : stage loaded at the acceptance edge
//   resp_o      : last stage, visible LAT cycles after acceptance
module dsram_lat_pipe
   import data_sram_resp_pkg::*;
#(
   parameter int unsigned LAT = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  dsram_resp_t resp_i,
   output dsram_resp_t resp_o
);

   logic [LAT-1:0]               valid_q, valid_d;
   logic [LAT-1:0]               err_q, err_d;
   logic [DSRAM_RESP_DATA_W-1:0] data_q [LAT];
   logic [DSRAM_RESP_DATA_W-1:0] data_d [LAT];

   always_comb begin
      valid_d[0] = resp_i.valid;
      err_d[0]   = resp_i.err;
      data_d[0]  = resp_i.data;
      for (int unsigned i = 1; i < LAT; i++) begin
         valid_d[i] = valid_q[i-1];
         err_d[i]   = err_q[i-1];
         data_d[i]  = data_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         err_q   <= '0;
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Data is qualified by valid, so it needs no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   always_comb begin
      resp_o.valid = valid_q[LAT-1];
      resp_o.err   = err_q[LAT-1];
      resp_o.data  = data_q[LAT-1];
   end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: word-organised RAM with byte write enables, fixed read latency,
// out-of-range detection and a sticky read-data output.
//   clk, resetn : clock, async active-low reset (array contents are not reset)
//   sram        : data_sram_resp_if slave (en/we/addr/wdata in, rdata/rdata_valid/addr_err out)
//   stat_*_cnt  : read/write/error counters, present only when DSRAM_STAT_EN is defined
// Parameters: DEPTH_LOG2 (log2 words), BASE_ADDR (byte address of word 0, 4-byte aligned),
// RD_LAT (read latency, 1..4).
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned RD_LAT     = 1
) (
   input logic             clk,
   input logic             resetn,
   data_sram_resp_if.slave sram
`ifdef DSRAM_STAT_EN
   ,
   output logic [31:0]     stat_rd_cnt,
   output logic [31:0]     stat_wr_cnt,
   output logic [31:0]     stat_err_cnt
`endif
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("data_sram_resp: RD_LAT must be in 1..4");
   end
   if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("data_sram_resp: BASE_ADDR must be 4-byte aligned");
   end

   logic [29:0]             off_word;
   logic                    in_range;
   logic [DEPTH_LOG2-1:0]   idx;
   logic                    acc_rd, acc_wr;
   logic [DSRAM_WORD_W-1:0] mem_q [Depth];
   dsram_resp_t             pipe_in, pipe_out;
   logic [DSRAM_WORD_W-1:0] rdata_hold_q, rdata_hold_d;

   // BASE_ADDR is aligned, so a word-granular subtraction equals the byte one shifted by 2.
   // Addresses below BASE_ADDR wrap to large offsets and fail the range check.
   always_comb begin
      off_word      = sram.addr[31:2] - BASE_ADDR[31:2];
      in_range      = (off_word >> DEPTH_LOG2) == '0;
      idx           = off_word[DEPTH_LOG2-1:0];
      acc_rd        = sram.en && (sram.we == '0);
      acc_wr        = sram.en && (sram.we != '0);
      pipe_in.valid = acc_rd;
      pipe_in.err   = sram.en && !in_range;
      pipe_in.data  = (acc_rd && in_range) ? mem_q[idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (acc_wr && in_range) begin
         mem_q[idx] <= dsram_merge(mem_q[idx], sram.wdata, sram.we);
      end
   end

   dsram_lat_pipe #(
      .LAT (RD_LAT)
   ) u_pipe (
      .clk    (clk),
      .resetn (resetn),
      .resp_i (pipe_in),
      .resp_o (pipe_out)
   );

   // rdata shows the fresh response in its slot, then the hold register keeps it.
   always_comb begin
      rdata_hold_d = rdata_hold_q;
      if (pipe_out.valid) rdata_hold_d = pipe_out.data;
      sram.rdata       = rdata_hold_d;
      sram.rdata_valid = pipe_out.valid;
      sram.addr_err    = pipe_out.err;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rdata_hold_q <= '0;
      else         rdata_hold_q <= rdata_hold_d;
   end

`ifdef DSRAM_STAT_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [31:0] err_cnt_q, err_cnt_d;

   always_comb begin
      rd_cnt_d  = rd_cnt_q + {31'd0, acc_rd};
      wr_cnt_d  = wr_cnt_q + {31'd0, acc_wr};
      err_cnt_d = err_cnt_q + {31'd0, pipe_out.err};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign stat_rd_cnt  = rd_cnt_q;
   assign stat_wr_cnt  = wr_cnt_q;
   assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: instance A (default geometry, RD_LAT=1) runs a vector table;
// instance B (DEPTH_LOG2=4, BASE_ADDR=0x1000, RD_LAT=3) runs latency, range and reset sequences.
module tb_data_sram_resp;
   import data_sram_resp_pkg::*;

   logic clk = 1'b0;
   logic resetn_a = 1'b0;
   logic resetn_b = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   data_sram_resp_if ifa ();
   data_sram_resp_if ifb ();

`ifdef DSRAM_STAT_EN
   logic [31:0] a_rd_cnt, a_wr_cnt, a_err_cnt;
   logic [31:0] b_rd_cnt, b_wr_cnt, b_err_cnt;
`endif

   data_sram_resp #(
      .DEPTH_LOG2 (12),
      .BASE_ADDR  (32'h0000_0000),
      .RD_LAT     (1)
   ) dut_a (
      .clk          (clk),
      .resetn       (resetn_a),
      .sram         (ifa.slave)
`ifdef DSRAM_STAT_EN
      ,
      .stat_rd_cnt  (a_rd_cnt),
      .stat_wr_cnt  (a_wr_cnt),
      .stat_err_cnt (a_err_cnt)
`endif
   );

   data_sram_resp #(
      .DEPTH_LOG2 (4),
      .BASE_ADDR  (32'h0000_1000),
      .RD_LAT     (3)
   ) dut_b (
      .clk          (clk),
      .resetn       (resetn_b),
      .sram         (ifb.slave)
`ifdef DSRAM_STAT_EN
      ,
      .stat_rd_cnt  (b_rd_cnt),
      .stat_wr_cnt  (b_wr_cnt),
      .stat_err_cnt (b_err_cnt)
`endif
   );

   typedef struct {
      logic        en;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_valid;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic en, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata);
      ifa.en = en; ifa.we = we; ifa.addr = addr; ifa.wdata = wdata;
   endtask

   task automatic drive_b(input logic en, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata);
      ifb.en = en; ifb.we = we; ifb.addr = addr; ifb.wdata = wdata;
   endtask

   // One isolated access on B; response slot is 3 cycles after the request.
   task automatic req_b(input string name, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ev, input logic ee,
                        input logic [31:0] ed);
      drive_b(1'b1, we, addr, wdata);
      for (int t = 1; t <= 3; t++) begin
         tick();
         if (t == 1) drive_b(1'b0, 4'h0, 32'h0, 32'h0);
         if (t < 3) begin
            chk({name, " early valid"}, {31'd0, ifb.rdata_valid}, 32'd0);
            chk({name, " early err"}, {31'd0, ifb.addr_err}, 32'd0);
         end else begin
            chk({name, " valid"}, {31'd0, ifb.rdata_valid}, {31'd0, ev});
            chk({name, " err"}, {31'd0, ifb.addr_err}, {31'd0, ee});
            chk({name, " rdata"}, ifb.rdata, ed);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] pl_addr [3];
      logic [31:0] pl_data [3];

      // en, we, addr, wdata, exp_valid, exp_err, exp_rdata (response one cycle later)
      vecs[0]  = '{1'b1, 4'hF, 32'h10,   32'h1122_3344, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 4'h2, 32'h10,   32'hAAAA_AAAA, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 4'h0, 32'h10,   32'h0,         1'b1, 1'b0, 32'h1122_AA44};
      vecs[3]  = '{1'b0, 4'hF, 32'h10,   32'hFFFF_FFFF, 1'b0, 1'b0, 32'h1122_AA44};
      vecs[4]  = '{1'b1, 4'hF, 32'h20,   32'h1234_5678, 1'b0, 1'b0, 32'h1122_AA44};
      vecs[5]  = '{1'b1, 4'hC, 32'h20,   32'hBEEF_BEEF, 1'b0, 1'b0, 32'h1122_AA44};
      vecs[6]  = '{1'b1, 4'h0, 32'h22,   32'h0,         1'b1, 1'b0, 32'hBEEF_5678};
      vecs[7]  = '{1'b1, 4'h0, 32'h10,   32'h0,         1'b1, 1'b0, 32'h1122_AA44};
      vecs[8]  = '{1'b1, 4'hF, 32'h0,    32'h0BAD_F00D, 1'b0, 1'b0, 32'h1122_AA44};
      vecs[9]  = '{1'b1, 4'hF, 32'h4000, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h1122_AA44};
      vecs[10] = '{1'b1, 4'h0, 32'h4000, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[11] = '{1'b1, 4'h0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0BAD_F00D};
      vecs[12] = '{1'b1, 4'hF, 32'h3FFC, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0BAD_F00D};
      vecs[13] = '{1'b1, 4'h0, 32'h3FFF, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D};
      vecs[14] = '{1'b1, 4'h1, 32'h11,   32'h5555_5555, 1'b0, 1'b0, 32'hCAFE_F00D};
      vecs[15] = '{1'b1, 4'h0, 32'h10,   32'h0,         1'b1, 1'b0, 32'h1122_AA55};
      vecs[16] = '{1'b0, 4'h0, 32'h0,    32'h0,         1'b0, 1'b0, 32'h1122_AA55};

      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      drive_b(1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      chk("reset a rdata", ifa.rdata, 32'h0);
      chk("reset a valid", {31'd0, ifa.rdata_valid}, 32'd0);
      chk("reset a err", {31'd0, ifa.addr_err}, 32'd0);
      chk("reset b rdata", ifb.rdata, 32'h0);
      chk("reset b valid", {31'd0, ifb.rdata_valid}, 32'd0);
      tick();
      resetn_a = 1'b1;
      resetn_b = 1'b1;
      tick();

      // Table on A (RD_LAT=1)
      for (int i = 0; i < 17; i++) begin
         drive_a(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         tick();
         chk($sformatf("vec%0d valid", i), {31'd0, ifa.rdata_valid}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("vec%0d err", i), {31'd0, ifa.addr_err}, {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d rdata", i), ifa.rdata, vecs[i].exp_rdata);
      end
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);

      // B: preload
      req_b("b wr0", 4'hF, 32'h1000, 32'hA0A0_A0A0, 1'b0, 1'b0, 32'h0);
      req_b("b wr1", 4'hF, 32'h1004, 32'hB1B1_B1B1, 1'b0, 1'b0, 32'h0);
      req_b("b wr2", 4'hF, 32'h1008, 32'hC2C2_C2C2, 1'b0, 1'b0, 32'h0);
      req_b("b wr3", 4'hF, 32'h103C, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0);

      // B: back-to-back reads, responses in three consecutive slots 3 cycles later
      pl_addr[0] = 32'h1000; pl_addr[1] = 32'h1004; pl_addr[2] = 32'h1008;
      pl_data[0] = 32'hA0A0_A0A0; pl_data[1] = 32'hB1B1_B1B1; pl_data[2] = 32'hC2C2_C2C2;
      drive_b(1'b1, 4'h0, pl_addr[0], 32'h0);
      for (int t = 1; t <= 7; t++) begin
         tick();
         if (t < 3) drive_b(1'b1, 4'h0, pl_addr[t], 32'h0);
         else       drive_b(1'b0, 4'h0, 32'h0, 32'h0);
         if (t >= 3 && t <= 5) begin
            chk($sformatf("pipe t%0d valid", t), {31'd0, ifb.rdata_valid}, 32'd1);
            chk($sformatf("pipe t%0d rdata", t), ifb.rdata, pl_data[t-3]);
         end else begin
            chk($sformatf("pipe t%0d valid", t), {31'd0, ifb.rdata_valid}, 32'd0);
            chk($sformatf("pipe t%0d rdata", t), ifb.rdata, (t < 3) ? 32'h0 : 32'hC2C2_C2C2);
         end
      end

      // B: out of range
      req_b("b oor rd", 4'h0, 32'h1040, 32'h0, 1'b1, 1'b1, 32'h0);
      req_b("b oor wr", 4'hF, 32'h0FFC, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
      req_b("b top rd", 4'h0, 32'h103C, 32'h0, 1'b1, 1'b0, 32'h5A5A_5A5A);

      // B: reset while a read is in flight
      drive_b(1'b1, 4'h0, 32'h1004, 32'h0);
      tick();
      drive_b(1'b0, 4'h0, 32'h0, 32'h0);
      #3 resetn_b = 1'b0;
      #1;
      chk("mid rst rdata", ifb.rdata, 32'h0);
      chk("mid rst valid", {31'd0, ifb.rdata_valid}, 32'd0);
      chk("mid rst err", {31'd0, ifb.addr_err}, 32'd0);
      tick();
      tick();
      resetn_b = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         chk($sformatf("post rst t%0d valid", t), {31'd0, ifb.rdata_valid}, 32'd0);
      end
      req_b("b keep2", 4'h0, 32'h1008, 32'h0, 1'b1, 1'b0, 32'hC2C2_C2C2);
      req_b("b keep0", 4'h0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'hA0A0_A0A0);

`ifdef DSRAM_STAT_EN
      // A: 5 reads, 3 writes, one read and one write out of range
      resetn_a = 1'b0;
      #1;
      chk("stat rst rd", a_rd_cnt, 32'd0);
      chk("stat rst wr", a_wr_cnt, 32'd0);
      chk("stat rst err", a_err_cnt, 32'd0);
      tick();
      resetn_a = 1'b1;
      drive_a(1'b1, 4'hF, 32'h100, 32'h1); tick();
      drive_a(1'b1, 4'h0, 32'h100, 32'h0); tick();
      drive_a(1'b1, 4'hF, 32'h104, 32'h2); tick();
      drive_a(1'b1, 4'h0, 32'h104, 32'h0); tick();
      drive_a(1'b1, 4'h3, 32'h5000, 32'h3); tick();
      drive_a(1'b1, 4'h0, 32'h0, 32'h0); tick();
      drive_a(1'b1, 4'h0, 32'h8000, 32'h0); tick();
      drive_a(1'b1, 4'h0, 32'h10, 32'h0); tick();
      drive_a(1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      tick();
      chk("stat rd", a_rd_cnt, 32'd5);
      chk("stat wr", a_wr_cnt, 32'd3);
      chk("stat err", a_err_cnt, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (memory side) of the CPU data-SRAM interface driven by the EX stage: en/we/addr/wdata in, rdata out.
- Holds a word-organised data memory with per-byte write enables.
- Returns read data after a fixed, parameterised latency; the MEM stage consumes it.
- Flags out-of-range accesses.
- Used as the data RAM in the core's simulation top and as the basis of the later bus bridge.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 32-bit words stored.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- RD_LAT, 1, read latency in cycles; legal range 1..4 (1 matches current MEM stage timing).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- data_sram_en  in  1  access request this cycle.
- data_sram_we  in  4  byte write enables; 0 = read.
- data_sram_addr  in  32  byte address; bits [1:0] ignored.
- data_sram_wdata  in  32  write data, already lane-replicated by the requester.
- data_sram_rdata  out  32  read data.
- rdata_valid  out  1  one-cycle pulse: rdata carries a fresh read response.
- addr_err  out  1  one-cycle pulse aligned with the response slot of an out-of-range access.

Behaviour:
- Reset (resetn low, async):
  - data_sram_rdata=0, rdata_valid=0, addr_err=0.
  - Latency pipeline cleared; in-flight reads are discarded and never produce rdata_valid.
  - Memory array contents are NOT reset.
- Index calculation:
  - idx = (addr - BASE_ADDR) >> 2, computed on 32 bits.
  - In range iff (addr - BASE_ADDR) < 4<<DEPTH_LOG2, unsigned.
  - Addresses below BASE_ADDR wrap to large values and are therefore out of range.
- Accepted access: every cycle with en=1. No backpressure; one access per cycle; no ready signal.
- Write (en=1, we!=0, in range):
  - At the rising edge, byte lane k of mem[idx] ← wdata[8k+7:8k] for each we[k]=1; other lanes unchanged.
  - No response pulse.
- Read (en=1, we=0):
  - mem[idx] sampled at the acceptance edge, then delayed RD_LAT-1 further edges.
  - data_sram_rdata updates and rdata_valid pulses in cycle N+RD_LAT for a request in cycle N.
- rdata hold: data_sram_rdata holds its last value between responses (sticky); only rdata_valid pulses.
- en=0: we/addr/wdata ignored; nothing enters the pipeline.
- Back-to-back ordering: a write in cycle N followed by a read of the same word in cycle N+1 returns the written data; the array is updated before the read samples it.
- Out-of-range write: dropped (memory unchanged). addr_err pulses RD_LAT cycles later.
- Out-of-range read: rdata=0, rdata_valid=1, addr_err=1 in the response slot.
- Pipeline:
  - RD_LAT stages, each stage = {valid, err, data}; shifts every cycle.
  - Full throughput: reads accepted every cycle produce responses every cycle.
- Illegal RD_LAT (outside 1..4): elaboration error.

Optional Feature:
- Macro: DSRAM_STAT_EN.
- Defined: adds three outputs, each 32 bits, reset to 0, wrapping at 2^32:
  - stat_rd_cnt: +1 per accepted read.
  - stat_wr_cnt: +1 per accepted write, in range or not.
  - stat_err_cnt: +1 per addr_err pulse.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header (alongside the existing macro header):
  - DSRAM_WORD_W=32 and DSRAM_BE_W=4.
  - Response-stage field widths, with a DSRAM_RESP_LEN bus-length define in the style of the existing *_LEN defines.
- Sub-module: dsram_lat_pipe.
  - Parameterised shift register of RD_LAT stages carrying {valid, err, data}.
  - Async active-low reset of valid/err only.
  - The top-level holds the array, the address check, the byte-write logic and the sticky output register.

Test Plan:
- Byte writes:
  - Stimulus: RD_LAT=1; write we=4'b1111 addr=0x10 wdata=0x11223344; then we=4'b0010 wdata=0xAAAAAAAA; then read 0x10.
  - Required: rdata=0x1122AA44 one cycle after the read; rdata_valid pulses once.
- Read-after-write and halfword lanes:
  - Stimulus: write 0x20 we=4'b1100 wdata=0xBEEFBEEF in cycle N; read 0x22 in cycle N+1.
  - Required: rdata[31:16]=0xBEEF; address bits [1:0] ignored.
- Latency and throughput:
  - Stimulus: RD_LAT=3; reads of 0x0, 0x4, 0x8 on consecutive cycles starting at cycle 10.
  - Required: rdata_valid high in cycles 13, 14, 15 with the matching data; rdata held afterward.
- Out of range:
  - Stimulus: DEPTH_LOG2=4, BASE_ADDR=0x1000; read 0x1040; write 0x0FFC.
  - Required: read returns rdata=0 with rdata_valid=1, addr_err=1; write leaves memory unchanged and produces an addr_err pulse with no rdata_valid.
- Reset mid-flight:
  - Stimulus: RD_LAT=2; issue a read, assert resetn=0 asynchronously one cycle later.
  - Required: outputs go to 0 immediately and no rdata_valid pulse follows; data written before reset is still readable afterward.
- Statistics (DSRAM_STAT_EN defined):
  - Stimulus: 5 reads, 3 writes, 2 of them out of range.
  - Required: stat_rd_cnt=5, stat_wr_cnt=3, stat_err_cnt=2.
